regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and address width at 3 bits, matching the 8x8 register file.
REQ-002 The block SHALL have these ports, in this order:
 - clock  in  1  single clock; all state updates on its rising edge.
 - reset_n  in  1  asynchronous, active-low reset.
 - a_req  in  1  requester A access request; held until a_ack.
 - a_we  in  1  requester A command: 1 = write, 0 = read.
 - a_addr  in  3  requester A register address.
 - a_wdata  in  8  requester A write data.
 - a_ack  out  1  one-cycle grant pulse to A.
 - a_rvalid  out  1  one-cycle pulse: a_rdata carries A's read result.
 - a_rdata  out  8  A read data; holds until A's next read result.
 - b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as the A ports, for requester B.
 - rf_address  out  3  register file address.
 - rf_write  out  1  register file write enable.
 - rf_in  out  8  register file write data.
 - rf_out  in  8  register file read data; registered, valid one cycle after a non-write access.
 - busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, GRANT and RESP.
REQ-004 In IDLE, if any req is high at a clock edge, the FSM SHALL select a winner, latch the winner's we/addr/wdata, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin via a last-winner pointer.
 - If only one req is high, that requester wins.
 - If both are high, the requester that did not win last time wins.
 - The pointer updates on every grant.
REQ-006 In GRANT, the block SHALL drive rf_address and rf_in from the latched command, drive rf_write equal to the latched we, and pulse the winner's ack for exactly one cycle.
REQ-007 From GRANT, a write SHALL go to IDLE and a read SHALL go to RESP.
REQ-008 In RESP, rf_write SHALL be 0, and at the RESP-exit edge rf_out SHALL be loaded into the winner's rdata register.
REQ-009 The winner's rvalid SHALL pulse high for the single cycle after RESP; RESP SHALL always go to IDLE.
REQ-010 rf_write SHALL be 0 in every state except a write GRANT.
REQ-011 The other requester's ack, rvalid and rdata SHALL not change during a transaction.
REQ-012 Latency SHALL be as follows, with req sampled high at the edge ending cycle 0:
 - write: ack in cycle 1; register updated at the end of cycle 1.
 - read: ack in cycle 1, RESP in cycle 2, rvalid with data in cycle 3.
 - Peak throughput: one write per 2 cycles, one read per 3 cycles.
REQ-013 The rvalid cycle SHALL overlap IDLE, so a new grant may be decided at the edge ending the rvalid cycle.
REQ-014 If req drops after being sampled but before ack, the latched transaction SHALL still complete unchanged.
REQ-015 A requester holding req high after its ack edge SHALL be treated as a new request.
REQ-016 A read issued after a completed write to the same address SHALL return the new data, whichever requester wrote it.
REQ-017 No starvation: with both reqs held continuously, grants SHALL strictly alternate A, B, A, B.

Reset
REQ-018 While reset_n is low, the block SHALL immediately force:
 - FSM state to IDLE;
 - a_ack, b_ack, a_rvalid, b_rvalid, rf_write and busy to 0;
 - rf_address, rf_in, a_rdata and b_rdata to 0;
 - the last-winner pointer to B, so A wins the first tie.
REQ-019 Reset asserted mid-transaction SHALL abort the transaction with no ack or rvalid emitted afterwards.
 - A write in GRANT aborted asynchronously SHALL not be guaranteed to commit.
 - Register file contents are not reset by this block.
REQ-020 After reset_n deasserts, the first edge SHALL evaluate requests normally.

Verification
REQ-021 Write then read by A: A writes 0x5A to addr 3 (ack cycle 1), then reads addr 3 -> a_ack pulses once for each request, a_rvalid pulses 3 cycles after the read req is sampled with a_rdata=0x5A, and b_ack/b_rvalid stay 0.
REQ-022 Tie: A and B both request from reset (A reads addr 1, B writes 0xFF to addr 2), reqs held -> A granted first, B granted in the first IDLE decision after A's rvalid cycle, then A again; grants strictly alternate.
REQ-023 Cross-requester coherency: B writes 0x81 to addr 7, then A reads addr 7 -> a_rdata=0x81 and b_rdata unchanged.
REQ-024 Early drop: A req is sampled for a read of addr 0 (holding 0x33), then a_req is dropped in the GRANT cycle -> the transaction completes with a_rvalid and a_rdata=0x33.
REQ-025 Reset mid-read: reset_n pulsed low during RESP -> busy=0, no a_rvalid, a_rdata=0, and the next tie is won by A.
REQ-026 Idle: no req for 20 cycles -> rf_write stays 0, busy stays 0, and all ack/rvalid stay 0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of an 8x8 register file with a
// registered read port; one access in flight at a time.
module regfile_arbiter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic [2:0] rf_address,
    output logic       rf_write,
    output logic [7:0] rf_in,
    input  logic [7:0] rf_out,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t state;
    logic   last_b;
    logic   win_b;
    logic   cmd_we;
    logic   pick_b;

    // On a tie the requester that lost last time wins.
    function automatic logic rr_pick(input logic ra, input logic rb, input logic lb);
        if (ra && rb) return !lb;
        return rb;
    endfunction

    assign pick_b = rr_pick(a_req, b_req, last_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            win_b      <= 1'b0;
            cmd_we     <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= 8'h00;
            b_rdata    <= 8'h00;
            rf_address <= 3'd0;
            rf_write   <= 1'b0;
            rf_in      <= 8'h00;
            busy       <= 1'b0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state  <= GRANT;
                        busy   <= 1'b1;
                        win_b  <= pick_b;
                        last_b <= pick_b;
                        if (pick_b) begin
                            b_ack      <= 1'b1;
                            cmd_we     <= b_we;
                            rf_write   <= b_we;
                            rf_address <= b_addr;
                            rf_in      <= b_wdata;
                        end else begin
                            a_ack      <= 1'b1;
                            cmd_we     <= a_we;
                            rf_write   <= a_we;
                            rf_address <= a_addr;
                            rf_in      <= a_wdata;
                        end
                    end
                end
                GRANT: begin
                    rf_write <= 1'b0;
                    if (cmd_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // rf_out now holds the word addressed during GRANT.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (win_b) begin
                        b_rvalid <= 1'b1;
                        b_rdata  <= rf_out;
                    end else begin
                        a_rvalid <= 1'b1;
                        a_rdata  <= rf_out;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rf_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_regfile_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, a_rvalid, b_ack, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [2:0] rf_address;
    logic       rf_write;
    logic [7:0] rf_in, rf_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    regfile_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_address(rf_address), .rf_write(rf_write), .rf_in(rf_in),
        .rf_out(rf_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // Register file: write on rf_write, registered read every cycle.
    logic [7:0] rf_mem [8];
    logic       init_mem = 1'b1;
    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h10 + 8'(i);
        end else if (rf_write) begin
            rf_mem[rf_address] <= rf_in;
        end
        rf_out <= rf_mem[rf_address];
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic zero_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
    endtask

    // Leaves the bench at rising edge + 1 with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        init_mem = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       a_req, a_we;
        logic [2:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_req, b_we;
        logic [2:0] b_addr;
        logic [7:0] b_wdata;
        logic [5:0] x_flags;   // {a_ack, b_ack, a_rvalid, b_rvalid, busy, rf_write}
        logic [7:0] x_ard, x_brd;
    } vec_t;

    function automatic vec_t mk(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                                input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd,
                                input logic [5:0] fl, input logic [7:0] ard, input logic [7:0] brd);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        v.x_flags = fl; v.x_ard = ard; v.x_brd = brd;
        return v;
    endfunction

    vec_t tbl [18];

    // Transaction-level reference model state for the random run.
    localparam int NR = 800;
    bit         e_ack  [2][NR+8];
    bit         e_rv   [2][NR+8];
    logic [7:0] e_rd   [2][NR+8];
    bit         e_busy [NR+8];
    bit         e_rfw  [NR+8];
    logic [7:0] m_mem  [8];
    logic [7:0] m_rd   [2];
    bit         m_last_b;
    int         free_c;
    bit         rq [2], rwe [2], pack [2];
    logic [2:0] rad [2];
    logic [7:0] rwd [2];

    initial begin
        reset_n = 1'b1;
        zero_inputs();
        #1 reset_n = 1'b0;
        #1;
        chk("rst.a_ack", 8'(a_ack), 8'h00);
        chk("rst.b_ack", 8'(b_ack), 8'h00);
        chk("rst.a_rvalid", 8'(a_rvalid), 8'h00);
        chk("rst.b_rvalid", 8'(b_rvalid), 8'h00);
        chk("rst.rf_write", 8'(rf_write), 8'h00);
        chk("rst.busy", 8'(busy), 8'h00);
        chk("rst.rf_address", 8'(rf_address), 8'h00);
        chk("rst.rf_in", rf_in, 8'h00);
        chk("rst.a_rdata", a_rdata, 8'h00);
        chk("rst.b_rdata", b_rdata, 8'h00);

        // Tie from reset: A reads addr 1, B writes 0xFF to addr 2, both held.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd2; b_wdata = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            chk($sformatf("tie%0d.a_ack", c), 8'(a_ack), 8'((c == 1) || (c == 6) || (c == 11)));
            chk($sformatf("tie%0d.b_ack", c), 8'(b_ack), 8'((c == 4) || (c == 9) || (c == 14)));
            chk($sformatf("tie%0d.a_rvalid", c), 8'(a_rvalid), 8'((c == 3) || (c == 8) || (c == 13)));
            chk($sformatf("tie%0d.b_rvalid", c), 8'(b_rvalid), 8'h00);
            chk($sformatf("tie%0d.rf_write", c), 8'(rf_write), 8'((c == 4) || (c == 9) || (c == 14)));
            chk($sformatf("tie%0d.a_rdata", c), a_rdata, (c >= 3) ? 8'h11 : 8'h00);
            @(posedge clock);
            #1;
        end

        // Write/read by A, cross-requester coherency, early drop in GRANT.
        tbl[0]  = mk(1'b1,1'b1,3'd3,8'h5A, 1'b0,1'b0,3'd0,8'h00, 6'b000000, 8'h00, 8'h00);
        tbl[1]  = mk(1'b1,1'b1,3'd3,8'h5A, 1'b0,1'b0,3'd0,8'h00, 6'b100011, 8'h00, 8'h00);
        tbl[2]  = mk(1'b1,1'b0,3'd3,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b000000, 8'h00, 8'h00);
        tbl[3]  = mk(1'b1,1'b0,3'd3,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b100010, 8'h00, 8'h00);
        tbl[4]  = mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b000010, 8'h00, 8'h00);
        tbl[5]  = mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b001000, 8'h5A, 8'h00);
        tbl[6]  = mk(1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd7,8'h81, 6'b000000, 8'h5A, 8'h00);
        tbl[7]  = mk(1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd7,8'h81, 6'b010011, 8'h5A, 8'h00);
        tbl[8]  = mk(1'b1,1'b0,3'd7,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b000000, 8'h5A, 8'h00);
        tbl[9]  = mk(1'b1,1'b0,3'd7,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b100010, 8'h5A, 8'h00);
        tbl[10] = mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b000010, 8'h5A, 8'h00);
        tbl[11] = mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b001000, 8'h81, 8'h00);
        tbl[12] = mk(1'b1,1'b1,3'd0,8'h33, 1'b0,1'b0,3'd0,8'h00, 6'b000000, 8'h81, 8'h00);
        tbl[13] = mk(1'b1,1'b1,3'd0,8'h33, 1'b0,1'b0,3'd0,8'h00, 6'b100011, 8'h81, 8'h00);
        tbl[14] = mk(1'b1,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b000000, 8'h81, 8'h00);
        tbl[15] = mk(1'b0,1'b0,3'd5,8'hEE, 1'b0,1'b0,3'd0,8'h00, 6'b100010, 8'h81, 8'h00);
        tbl[16] = mk(1'b0,1'b0,3'd5,8'hEE, 1'b0,1'b0,3'd0,8'h00, 6'b000010, 8'h81, 8'h00);
        tbl[17] = mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 6'b001000, 8'h33, 8'h00);
        do_reset();
        for (int k = 0; k < 18; k++) begin
            a_req = tbl[k].a_req; a_we = tbl[k].a_we; a_addr = tbl[k].a_addr; a_wdata = tbl[k].a_wdata;
            b_req = tbl[k].b_req; b_we = tbl[k].b_we; b_addr = tbl[k].b_addr; b_wdata = tbl[k].b_wdata;
            @(negedge clock);
            chk($sformatf("tbl%0d.flags", k), 8'({a_ack, b_ack, a_rvalid, b_rvalid, busy, rf_write}),
                8'(tbl[k].x_flags));
            chk($sformatf("tbl%0d.a_rdata", k), a_rdata, tbl[k].x_ard);
            chk($sformatf("tbl%0d.b_rdata", k), b_rdata, tbl[k].x_brd);
            @(posedge clock);
            #1;
        end

        // Idle for 20 cycles.
        zero_inputs();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk($sformatf("idle%0d.flags", c), 8'({a_ack, b_ack, a_rvalid, b_rvalid, busy, rf_write}), 8'h00);
            @(posedge clock);
            #1;
        end

        // Reset pulsed during RESP of an A read of addr 0.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
        @(negedge clock);
        chk("rr.c0.busy", 8'(busy), 8'h00);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rr.c1.a_ack", 8'(a_ack), 8'h01);
        @(posedge clock);
        #1;
        a_req = 1'b0;
        #1;
        chk("rr.resp.busy", 8'(busy), 8'h01);
        reset_n = 1'b0;
        #1;
        chk("rr.rst.busy", 8'(busy), 8'h00);
        chk("rr.rst.a_rdata", a_rdata, 8'h00);
        chk("rr.rst.a_rvalid", 8'(a_rvalid), 8'h00);
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 8'hC3;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd6; b_wdata = 8'h3C;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rr.after.a_ack", 8'(a_ack), 8'h01);
        chk("rr.after.b_ack", 8'(b_ack), 8'h00);
        chk("rr.after.a_rvalid", 8'(a_rvalid), 8'h00);
        chk("rr.after.a_rdata", a_rdata, 8'h00);
        @(posedge clock);
        #1;

        // Randomized run against the transaction-level model.
        do_reset();
        m_mem = rf_mem;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        m_last_b = 1'b1;
        free_c = 0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0; pack[r] = 1'b0; rwe[r] = 1'b0; rad[r] = 3'd0; rwd[r] = 8'h00;
        end
        for (int c = 0; c < NR; c++) begin
            for (int r = 0; r < 2; r++) begin
                bit newcmd;
                newcmd = 1'b0;
                if (rq[r] && pack[r]) begin
                    rq[r] = ($urandom_range(0, 2) != 0);
                    newcmd = rq[r];
                end else if (rq[r]) begin
                    if ($urandom_range(0, 7) == 0) rq[r] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    rq[r] = 1'b1;
                    newcmd = 1'b1;
                end
                if (newcmd) begin
                    rwe[r] = 1'($urandom_range(0, 1));
                    rad[r] = 3'($urandom_range(0, 7));
                    rwd[r] = 8'($urandom_range(0, 255));
                end
            end
            a_req = rq[0]; a_we = rwe[0]; a_addr = rad[0]; a_wdata = rwd[0];
            b_req = rq[1]; b_we = rwe[1]; b_addr = rad[1]; b_wdata = rwd[1];
            @(negedge clock);
            for (int r = 0; r < 2; r++)
                if (e_rv[r][c]) m_rd[r] = e_rd[r][c];
            chk($sformatf("rnd%0d.a_ack", c), 8'(a_ack), 8'(e_ack[0][c]));
            chk($sformatf("rnd%0d.b_ack", c), 8'(b_ack), 8'(e_ack[1][c]));
            chk($sformatf("rnd%0d.a_rvalid", c), 8'(a_rvalid), 8'(e_rv[0][c]));
            chk($sformatf("rnd%0d.b_rvalid", c), 8'(b_rvalid), 8'(e_rv[1][c]));
            chk($sformatf("rnd%0d.a_rdata", c), a_rdata, m_rd[0]);
            chk($sformatf("rnd%0d.b_rdata", c), b_rdata, m_rd[1]);
            chk($sformatf("rnd%0d.busy", c), 8'(busy), 8'(e_busy[c]));
            chk($sformatf("rnd%0d.rf_write", c), 8'(rf_write), 8'(e_rfw[c]));
            pack[0] = a_ack;
            pack[1] = b_ack;
            // A decision is taken at the edge ending this cycle if the block is free.
            if (c >= free_c && (rq[0] || rq[1])) begin
                int w;
                w = (rq[0] && rq[1]) ? (m_last_b ? 0 : 1) : (rq[1] ? 1 : 0);
                m_last_b = (w == 1);
                e_ack[w][c+1] = 1'b1;
                e_busy[c+1]   = 1'b1;
                if (rwe[w]) begin
                    e_rfw[c+1] = 1'b1;
                    m_mem[rad[w]] = rwd[w];
                    free_c = c + 2;
                end else begin
                    e_busy[c+2] = 1'b1;
                    e_rv[w][c+3] = 1'b1;
                    e_rd[w][c+3] = m_mem[rad[w]];
                    free_c = c + 3;
                end
            end
            @(posedge clock);
            #1;
        end
        zero_inputs();
        repeat (4) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
